// File: rtl/core_pkg.sv
// Shared core definitions: register-file geometry, write-back request bundle
// and the write-back arbiter state encoding.
package core_pkg;

    localparam int NREG       = 32;
    localparam int AW         = 5;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [DW-1:0] data_t;

    typedef enum logic [0:0] {
        ALU_PRI  = 1'b0,
        LONG_PRI = 1'b1
    } arb_state_t;

    // One write-back request as seen by the register-file write port.
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        data_t    data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter.sv
// Write-port arbiter: ALU path normally wins, the long-latency path is promoted
// for one grant after STARVE_MAX consecutive denials.
module wb_arbiter
    import core_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     alu_wb_valid,
    input  reg_idx_t alu_wb_rd,
    input  data_t    alu_wb_data,
    input  logic     long_wb_valid,
    input  reg_idx_t long_wb_rd,
    input  data_t    long_wb_data,
    output logic     alu_wb_ready,
    output logic     long_wb_ready,
    output wb_req_t  grant
);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                alu_grant;
    logic                long_grant;

    // Ready generation and grant muxing; reset presents the ALU-priority view.
    // NOTE: every signal assigned in an always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        alu_wb_ready  = 1'b1;
        long_wb_ready = !alu_wb_valid;
        if (!RST && state_q == LONG_PRI) begin
            long_wb_ready = 1'b1;
            alu_wb_ready  = !long_wb_valid;
        end
        alu_grant  = alu_wb_valid & alu_wb_ready;
        long_grant = long_wb_valid & long_wb_ready;
        grant      = '0;
        if (alu_grant) begin
            grant = '{valid: 1'b1, rd: alu_wb_rd, data: alu_wb_data};
        end else if (long_grant) begin
            grant = '{valid: 1'b1, rd: long_wb_rd, data: long_wb_data};
        end
    end

    // Starvation counter and priority state transitions.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        if (long_grant || !long_wb_valid) begin
            starve_cnt_d = '0;
        end else if (state_q == ALU_PRI && starve_cnt_q != STARVE_W'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
        if (state_q == ALU_PRI) begin
            if (long_wb_valid && !long_wb_ready &&
                starve_cnt_q == STARVE_W'(STARVE_MAX - 1)) begin
                state_d = LONG_PRI;
            end
        end else if (long_grant || !long_wb_valid) begin
            state_d = ALU_PRI;
        end
    end

    // Arbiter state registers.
    // NOTE: sequential blocks use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ALU_PRI;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: owns the register-file write port, keeps the
// pending-write scoreboard used for RAW/WAW issue stalls, and flags writes
// that arrive for registers with no outstanding producer.
module regfile_wb_scheduler
    import core_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            issue_valid,
    input  reg_idx_t        issue_rs,
    input  reg_idx_t        issue_rt,
    input  reg_idx_t        issue_rd,
    output logic            issue_stall,
    input  logic            alu_wb_valid,
    input  reg_idx_t        alu_wb_rd,
    input  data_t           alu_wb_data,
    output logic            alu_wb_ready,
    input  logic            long_wb_valid,
    input  reg_idx_t        long_wb_rd,
    input  data_t           long_wb_data,
    output logic            long_wb_ready,
    output logic            rf_we,
    output reg_idx_t        rf_waddr,
    output data_t           rf_wdata,
    output logic [NREG-1:0] busy_mask,
    output logic            wb_err
);

    wb_req_t         grant;
    logic [NREG-1:0] pending_q, pending_d;
    logic            rf_we_q, rf_we_d;
    reg_idx_t        rf_waddr_q, rf_waddr_d;
    data_t           rf_wdata_q, rf_wdata_d;
    logic            wb_err_q, wb_err_d;
    logic            issue_accept;
    logic            wb_writes;

    wb_arbiter u_arb (
        .CLK           (CLK),
        .RST           (RST),
        .alu_wb_valid  (alu_wb_valid),
        .alu_wb_rd     (alu_wb_rd),
        .alu_wb_data   (alu_wb_data),
        .long_wb_valid (long_wb_valid),
        .long_wb_rd    (long_wb_rd),
        .long_wb_data  (long_wb_data),
        .alu_wb_ready  (alu_wb_ready),
        .long_wb_ready (long_wb_ready),
        .grant         (grant)
    );

    // Hazard check against registered pending bits only.
    always_comb begin
        issue_stall  = !RST && issue_valid &&
                       (pending_q[issue_rs] || pending_q[issue_rt] || pending_q[issue_rd]);
        issue_accept = issue_valid && !issue_stall;
    end

    // Scoreboard, write-port and error next-state.
    always_comb begin
        wb_writes = grant.valid && (grant.rd != '0);
        pending_d = pending_q;
        if (wb_writes) begin
            pending_d[grant.rd] = 1'b0;
        end
        if (issue_accept && issue_rd != '0) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
        rf_we_d    = wb_writes;
        rf_waddr_d = wb_writes ? grant.rd   : rf_waddr_q;
        rf_wdata_d = wb_writes ? grant.data : rf_wdata_q;
        wb_err_d   = wb_err_q || (wb_writes && !pending_q[grant.rd]);
    end

    // Scoreboard and registered write port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign busy_mask = pending_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: reset checks, a directed vector table,
// hand-written error/reset sequences and a random run against a reference model.
module tb_regfile_wb_scheduler;

    localparam int STARVE_MAX = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        issue_valid;
    logic [4:0]  issue_rs, issue_rt, issue_rd;
    logic        issue_stall;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        alu_wb_ready;
    logic        long_wb_valid;
    logic [4:0]  long_wb_rd;
    logic [31:0] long_wb_data;
    logic        long_wb_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;
    logic        wb_err;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_scheduler dut (
        .CLK           (CLK),
        .RST           (RST),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rt      (issue_rt),
        .issue_rd      (issue_rd),
        .issue_stall   (issue_stall),
        .alu_wb_valid  (alu_wb_valid),
        .alu_wb_rd     (alu_wb_rd),
        .alu_wb_data   (alu_wb_data),
        .alu_wb_ready  (alu_wb_ready),
        .long_wb_valid (long_wb_valid),
        .long_wb_rd    (long_wb_rd),
        .long_wb_data  (long_wb_data),
        .long_wb_ready (long_wb_ready),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .busy_mask     (busy_mask),
        .wb_err        (wb_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        iv;
        logic [4:0]  rs, rt, rd;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        stall, ardy, lrdy;
        logic [31:0] busy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[20];

    // Reference model state for the random run.
    logic [31:0] m_pend;
    logic        m_err, m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        issue_valid   = iv;  issue_rs = rs; issue_rt = rt; issue_rd = rd;
        alu_wb_valid  = av;  alu_wb_rd  = ard; alu_wb_data  = ad;
        long_wb_valid = lv;  long_wb_rd = lrd; long_wb_data = ld;
    endtask

    function automatic vec_t mk(logic iv, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic av, logic [4:0] ard, logic [31:0] ad,
                                logic lv, logic [4:0] lrd, logic [31:0] ld,
                                logic st, logic ar, logic lr, logic [31:0] busy,
                                logic we, logic [4:0] wa, logic [31:0] wd);
        vec_t v;
        v.iv = iv; v.rs = rs; v.rt = rt; v.rd = rd;
        v.av = av; v.ard = ard; v.ad = ad;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.stall = st; v.ardy = ar; v.lrdy = lr; v.busy = busy;
        v.we = we; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    // Pick a write-back destination, mostly among registers the model sees as pending.
    function automatic logic [4:0] pick();
        int r = $urandom_range(0, 7);
        if ($urandom_range(0, 3) != 0) begin
            for (int k = 0; k < 8; k++) begin
                if (m_pend[(r + k) % 8]) return 5'((r + k) % 8);
            end
        end
        return 5'(r);
    endfunction

    initial begin
        logic        a_act, l_act;
        logic [4:0]  a_rd, l_rd;
        logic [31:0] a_data, l_data;
        logic        m_stall, m_lprio, m_ardy, m_lrdy, m_ag, m_lg, wb_v;
        logic [4:0]  wb_rd;
        logic [31:0] wb_d;

        // ---------------- reset with random inputs ----------------
        RST = 1'b1;
        drive(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("rst_stall", issue_stall, 0);
            check("rst_alu_rdy", alu_wb_ready, 1);
            check("rst_long_rdy", long_wb_ready, !alu_wb_valid);
            check("rst_busy", busy_mask, 0);
            check("rst_we", rf_we, 0);
            check("rst_waddr", rf_waddr, 0);
            check("rst_wdata", rf_wdata, 0);
            check("rst_err", wb_err, 0);
            step();
            drive(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
        end
        RST = 1'b0;

        // ---------------- directed vector table ----------------
        // RAW stall on r5, then ALU write-back clears it.
        vecs[0]  = mk(1,1,2,5, 0,0,0,           0,0,0,        0,1,1, 32'h0,  0,0,0);
        vecs[1]  = mk(1,5,0,6, 0,0,0,           0,0,0,        1,1,1, 32'h20, 0,0,0);
        vecs[2]  = mk(1,5,0,6, 0,0,0,           0,0,0,        1,1,1, 32'h20, 0,0,0);
        vecs[3]  = mk(1,5,0,6, 1,5,32'hDEADBEEF, 0,0,0,       1,1,0, 32'h20, 0,0,0);
        vecs[4]  = mk(1,5,0,6, 0,0,0,           0,0,0,        0,1,1, 32'h0,  1,5,32'hDEADBEEF);
        // Conflict: ALU r3 and long r7 in the same cycle.
        vecs[5]  = mk(1,0,0,3, 0,0,0,           0,0,0,        0,1,1, 32'h40, 0,0,0);
        vecs[6]  = mk(1,0,0,7, 0,0,0,           0,0,0,        0,1,1, 32'h48, 0,0,0);
        vecs[7]  = mk(0,0,0,0, 1,3,32'h33,      1,7,32'h77,   0,1,0, 32'hC8, 0,0,0);
        vecs[8]  = mk(0,0,0,0, 0,0,0,           1,7,32'h77,   0,1,1, 32'hC0, 1,3,32'h33);
        vecs[9]  = mk(0,0,0,0, 0,0,0,           0,0,0,        0,1,1, 32'h40, 1,7,32'h77);
        vecs[10] = mk(0,0,0,0, 0,0,0,           0,0,0,        0,1,1, 32'h40, 0,0,0);
        // Starvation: ALU writes r0 every cycle, long r6 waits.
        for (int i = 11; i < 15; i++)
            vecs[i] = mk(0,0,0,0, 1,0,32'hA0, 1,6,32'h66, 0,1,0, 32'h40, 0,0,0);
        vecs[15] = mk(0,0,0,0, 1,0,32'hA0,      1,6,32'h66,   0,0,1, 32'h40, 0,0,0);
        vecs[16] = mk(0,0,0,0, 1,0,32'hA0,      0,0,0,        0,1,0, 32'h0,  1,6,32'h66);
        vecs[17] = mk(0,0,0,0, 0,0,0,           0,0,0,        0,1,1, 32'h0,  0,0,0);
        // Issue to r0 never stalls and never becomes busy.
        vecs[18] = mk(1,0,0,0, 0,0,0,           0,0,0,        0,1,1, 32'h0,  0,0,0);
        vecs[19] = mk(1,0,0,0, 0,0,0,           0,0,0,        0,1,1, 32'h0,  0,0,0);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].iv, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                  vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
            @(negedge CLK);
            check($sformatf("vec%0d_stall", i), issue_stall, vecs[i].stall);
            check($sformatf("vec%0d_alu_rdy", i), alu_wb_ready, vecs[i].ardy);
            check($sformatf("vec%0d_long_rdy", i), long_wb_ready, vecs[i].lrdy);
            check($sformatf("vec%0d_busy", i), busy_mask, vecs[i].busy);
            check($sformatf("vec%0d_we", i), rf_we, vecs[i].we);
            if (vecs[i].we) begin
                check($sformatf("vec%0d_waddr", i), rf_waddr, vecs[i].wa);
                check($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].wd);
            end
            step();
        end

        // ---------------- write to non-pending r9 ----------------
        drive(0,0,0,0, 1,9,32'h99, 0,0,0);
        @(negedge CLK);
        check("err_pre", wb_err, 0);
        check("err_alu_rdy", alu_wb_ready, 1);
        step();
        drive(0,0,0,0, 0,0,0, 0,0,0);
        @(negedge CLK);
        check("err_set", wb_err, 1);
        check("err_we", rf_we, 1);
        check("err_waddr", rf_waddr, 9);
        check("err_wdata", rf_wdata, 32'h99);
        check("err_busy", busy_mask, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("err_sticky", wb_err, 1);
            check("err_we_idle", rf_we, 0);
            step();
        end

        // ---------------- reset mid-flight ----------------
        drive(1,0,0,2, 0,0,0, 0,0,0);
        step();
        drive(1,0,0,4, 0,0,0, 0,0,0);
        step();
        drive(0,0,0,0, 1,0,32'h1, 1,2,32'h22);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("mid_busy", busy_mask, 32'h14);
            check("mid_long_denied", long_wb_ready, 0);
            step();
        end
        RST = 1'b1;
        drive(1,2,4,1, 1,4,32'h44, 1,2,32'h22);
        @(negedge CLK);
        check("mid_rst_stall", issue_stall, 0);
        check("mid_rst_alu_rdy", alu_wb_ready, 1);
        check("mid_rst_long_rdy", long_wb_ready, 0);
        step();
        RST = 1'b0;
        drive(0,0,0,0, 1,0,32'h1, 1,2,32'h22);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                check("post_rst_busy", busy_mask, 0);
                check("post_rst_we", rf_we, 0);
                check("post_rst_err", wb_err, 0);
            end
            check($sformatf("post_rst_long_rdy%0d", k), long_wb_ready, (k == 4));
            check($sformatf("post_rst_alu_rdy%0d", k), alu_wb_ready, (k != 4));
            step();
        end
        drive(0,0,0,0, 1,0,32'h1, 0,0,0);
        @(negedge CLK);
        check("post_rst_long_we", rf_we, 1);
        check("post_rst_long_waddr", rf_waddr, 2);
        step();

        // ---------------- random run against reference model ----------------
        RST = 1'b1;
        drive(0,0,0,0, 0,0,0, 0,0,0);
        step();
        RST = 1'b0;
        m_pend = '0; m_err = 1'b0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_run = 0;
        a_act = 1'b0; l_act = 1'b0;
        a_rd = '0; l_rd = '0; a_data = '0; l_data = '0;
        for (int c = 0; c < 2000; c++) begin
            if (!a_act && $urandom_range(0, 1) == 1) begin
                a_act = 1'b1; a_rd = pick(); a_data = $urandom;
            end
            if (!l_act && $urandom_range(0, 2) == 0) begin
                l_act = 1'b1; l_rd = pick(); l_data = $urandom;
            end
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), a_act, a_rd, a_data, l_act, l_rd, l_data);
            @(negedge CLK);
            // Long path gets priority once it has been refused STARVE_MAX times in a row.
            m_stall = issue_valid && (m_pend[issue_rs] || m_pend[issue_rt] || m_pend[issue_rd]);
            m_lprio = (m_run >= STARVE_MAX);
            m_lrdy  = m_lprio || !a_act;
            m_ardy  = !(m_lprio && l_act);
            check("rand_stall", issue_stall, m_stall);
            check("rand_alu_rdy", alu_wb_ready, m_ardy);
            check("rand_long_rdy", long_wb_ready, m_lrdy);
            check("rand_busy", busy_mask, m_pend);
            check("rand_we", rf_we, m_we);
            check("rand_waddr", rf_waddr, m_waddr);
            check("rand_wdata", rf_wdata, m_wdata);
            check("rand_err", wb_err, m_err);
            m_ag  = a_act && m_ardy;
            m_lg  = l_act && m_lrdy;
            wb_v  = m_ag || m_lg;
            wb_rd = m_ag ? a_rd : l_rd;
            wb_d  = m_ag ? a_data : l_data;
            if (wb_v && wb_rd != 0) begin
                if (!m_pend[wb_rd]) m_err = 1'b1;
                m_pend[wb_rd] = 1'b0;
                m_we = 1'b1; m_waddr = wb_rd; m_wdata = wb_d;
            end else begin
                m_we = 1'b0;
            end
            if (issue_valid && !m_stall && issue_rd != 0) m_pend[issue_rd] = 1'b1;
            if (m_lg || !l_act) m_run = 0;
            else m_run++;
            if (m_ag) a_act = 1'b0;
            if (m_lg) l_act = 1'b0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
